// File: rtl/vec_alu_pkg.sv
`default_nettype none
// ============================================================================
// vec_alu_pkg : shared types, constants and helpers for the vector add/sub path
// Revision    : 1.0
// ============================================================================
package vec_alu_pkg;

  localparam int LANE_W     = 32;
  localparam int LANE_BYTES = LANE_W / 8;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10
  } sew_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  // High when byte k of a 32-bit lane is the lowest byte of an element.
  // The illegal encoding isolates every byte; its result is discarded anyway.
  function automatic logic elem_start(input logic [1:0] sew, input logic [1:0] k);
    case (sew_e'(sew))
      SEW8:    elem_start = 1'b1;
      SEW16:   elem_start = ~k[0];
      SEW32:   elem_start = (k == 2'd0);
      default: elem_start = 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_lane32.sv
`default_nettype none
// ============================================================================
// addsub_lane32 : four 8-bit add/sub slices with SEW-gated byte carries
// Revision      : 1.0
// ============================================================================
module addsub_lane32
  import vec_alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  sew,
  input  logic        sub,
  output logic [31:0] sum
);

  logic [3:0] cin;
  logic [2:0] cout;

  for (genvar k = 0; k < 4; k++) begin : g_byte
    logic [7:0] bk;
    assign bk = sub ? ~b[8*k +: 8] : b[8*k +: 8];

    if (k == 0) begin : g_first
      assign cin[k] = sub;
    end else begin : g_chain
      assign cin[k] = elem_start(sew, 2'(k)) ? sub : cout[k-1];
    end

    // The top byte's carry-out would leave the lane, so it is never formed.
    if (k < 3) begin : g_carry
      assign {cout[k], sum[8*k +: 8]} = {1'b0, a[8*k +: 8]} + {1'b0, bk} + {8'b0, cin[k]};
    end else begin : g_top
      assign sum[8*k +: 8] = a[8*k +: 8] + bk + {7'b0, cin[k]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/vec_addsub_seq.sv
`default_nettype none
// ============================================================================
// vec_addsub_seq : multi-cycle vector add/sub sequencer, one 32-bit chunk/clk
// Revision       : 1.0
// ============================================================================
module vec_addsub_seq
  import vec_alu_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] vs2,
  input  logic [1:0]      sew,
  input  logic            sub,
  input  logic [7:0]      vl,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [VLEN-1:0] vd,
  output logic            res_err,
  output logic            busy
);

  localparam int NCHUNK = VLEN / LANE_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
  localparam logic [15:0] MAX_E8  = 16'(VLEN / 8);
  localparam logic [15:0] MAX_E16 = 16'(VLEN / 16);
  localparam logic [15:0] MAX_E32 = 16'(VLEN / 32);

  seq_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VLEN-1:0] vs1_q, vs1_d;
  logic [VLEN-1:0] vs2_q, vs2_d;
  logic [VLEN-1:0] vd_q, vd_d;
  logic [1:0]      sew_q, sew_d;
  logic            sub_q, sub_d;
  logic [7:0]      vl_q, vl_d;
  logic            err_q, err_d;

  logic            accept;
  logic [LANE_W-1:0] lane_a, lane_b, lane_sum, lane_masked;
  logic [LANE_BYTES-1:0] keep;
  logic [CNT_W+1:0] byte_idx;
  logic [15:0]     elem_idx;
  logic [15:0]     max_elems;

  assign accept = start_valid & start_ready;
  assign lane_a = vs1_q[cnt_q*LANE_W +: LANE_W];
  assign lane_b = vs2_q[cnt_q*LANE_W +: LANE_W];

  addsub_lane32 u_lane (
    .a   (lane_a),
    .b   (lane_b),
    .sew (sew_q),
    .sub (sub_q),
    .sum (lane_sum)
  );

  // Tail masking: a byte survives only if its element index is below vl.
  always_comb begin
    keep     = '0;
    byte_idx = '0;
    elem_idx = '0;
    for (int k = 0; k < LANE_BYTES; k++) begin
      byte_idx = {cnt_q, 2'(k)};
      case (sew_e'(sew_q))
        SEW16:   elem_idx = 16'(byte_idx) >> 1;
        SEW32:   elem_idx = 16'(byte_idx) >> 2;
        default: elem_idx = 16'(byte_idx);
      endcase
      keep[k] = (elem_idx < {8'b0, vl_q}) && !err_q;
    end
  end

  always_comb begin
    lane_masked = '0;
    for (int k = 0; k < LANE_BYTES; k++) begin
      lane_masked[8*k +: 8] = lane_sum[8*k +: 8] & {8{keep[k]}};
    end
  end

  always_comb begin
    case (sew_e'(sew))
      SEW16:   max_elems = MAX_E16;
      SEW32:   max_elems = MAX_E32;
      default: max_elems = MAX_E8;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = CALC;
      CALC:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    start_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    res_valid   = (state_q == DONE);
    res_err     = (state_q == DONE) && err_q;
    vd          = vd_q;
  end

  // Datapath next values
  always_comb begin
    vs1_d = vs1_q;
    vs2_d = vs2_q;
    sew_d = sew_q;
    sub_d = sub_q;
    vl_d  = vl_q;
    err_d = err_q;
    vd_d  = vd_q;
    cnt_d = cnt_q;
    if (accept) begin
      vs1_d = vs1;
      vs2_d = vs2;
      sew_d = sew;
      sub_d = sub;
      vl_d  = ({8'b0, vl} > max_elems) ? max_elems[7:0] : vl;
      err_d = (sew == 2'b11);
      vd_d  = '0;
      cnt_d = '0;
    end else if (state_q == CALC) begin
      vd_d[cnt_q*LANE_W +: LANE_W] = lane_masked;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs1_q <= '0;
      vs2_q <= '0;
      sew_q <= '0;
      sub_q <= 1'b0;
      vl_q  <= '0;
      err_q <= 1'b0;
      vd_q  <= '0;
      cnt_q <= '0;
    end else begin
      vs1_q <= vs1_d;
      vs2_q <= vs2_d;
      sew_q <= sew_d;
      sub_q <= sub_d;
      vl_q  <= vl_d;
      err_q <= err_d;
      vd_q  <= vd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire
